cpu_ext_host: RTL and testbench

- Host-side initiator for the processor core's external memory ports: the instruction-memory port (addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext) and the data-memory port (addr_ext_2/wen_ext_2/ren_ext_2/wdata_ext_2/rdata_ext_2), plus the core's enable input.
- Accepts a valid/ready command stream from a test host or boot controller. Each command is one of: instruction-memory write or read, data-memory write or read, or a bounded run.
- Turns each command into correctly timed single-cycle memory strobes, or a gated enable window.
- Read results go back on a valid/ready response channel. The block sits between the host bus and the core top level.

---
 rtl/cpu_ext_host_pkg.sv | 37 +++
 rtl/cpu_ext_host_if.sv | 28 ++
 rtl/cpu_ext_host_cycle_counter.sv | 40 ++++
 rtl/cpu_ext_host.sv | 212 +++++++++++++++++++++
 tb/tb_cpu_ext_host.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ext_host_pkg.sv
// Shared definitions for the external-memory host initiator.
//   - opcode encodings carried on cmd_op
//   - FSM state encoding (also visible on the top-level state_dbg output)
//   - address alignment masks and a legality helper
package cpu_ext_host_pkg;

    localparam logic [2:0] OP_WR_I = 3'b000;
    localparam logic [2:0] OP_WR_D = 3'b001;
    localparam logic [2:0] OP_RD_I = 3'b010;
    localparam logic [2:0] OP_RD_D = 3'b011;
    localparam logic [2:0] OP_RUN  = 3'b100;

    // Instruction port is word (4-byte) addressed, data port is 8-byte addressed.
    localparam logic [63:0] ALIGN_I_MASK = 64'h3;
    localparam logic [63:0] ALIGN_D_MASK = 64'h7;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RESP     = 3'd4,
        ST_RUN      = 3'd5
    } state_t;

    // A command is legal when its op is known and its address is aligned
    // for the port it targets. RUN ignores the address.
    function automatic logic cmd_legal(input logic [2:0] op, input logic [63:0] addr);
        case (op)
            OP_WR_I, OP_RD_I: return (addr & ALIGN_I_MASK) == 64'd0;
            OP_WR_D, OP_RD_D: return (addr & ALIGN_D_MASK) == 64'd0;
            OP_RUN:           return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_ext_host_if.sv
// Host command/response channel of cpu_ext_host.
//   cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_wdata : command channel (host -> block)
//   rsp_valid/rsp_ready/rsp_data                  : read response channel (block -> host)
//
// Handshake: on both channels a transfer happens on the rising edge where
// valid and ready are both high. The sender holds valid and its payload
// stable until that edge; ready may change freely and never depends on
// valid combinationally (both ready and valid are registered here).
interface cpu_ext_host_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [63:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/cpu_ext_host_cycle_counter.sv
// Loadable down-counter with a registered zero flag.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one; saturates at zero, never wraps
//   zero      : registered, high when the held count is zero
module ext_host_cycle_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    always_comb begin
        count_nxt = count;
        if (load) begin
            count_nxt = load_val;
        end else if (dec && (count != '0)) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            zero  <= 1'b1;
        end else begin
            count <= count_nxt;
            zero  <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/cpu_ext_host.sv
// Host-side initiator for the core's instruction and data memory ports.
// Takes commands (write/read on either port, or a bounded RUN) and turns
// them into single-cycle write strobes, held read strobes with a response,
// or an enable window for the core.
//   clk, rst            : clock, synchronous active-high reset
//   host (slave)        : command and response channels
//   err                 : one-cycle pulse on illegal op / misaligned address
//   run_done            : one-cycle pulse when a RUN ends (count or halt)
//   busy                : high whenever the FSM is not in IDLE
//   halt                : aborts an active RUN, ignored otherwise
//   enable              : core enable
//   *_ext               : instruction memory port (32-bit data)
//   *_ext_2             : data memory port (64-bit data)
//   state_dbg           : current FSM state
// All outputs come straight from flops.
module cpu_ext_host
    import cpu_ext_host_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 32
) (
    input  logic          clk,
    input  logic          rst,
    cpu_ext_host_if.slave host,
    output logic          err,
    output logic          run_done,
    output logic          busy,
    input  logic          halt,
    output logic          enable,
    output logic [63:0]   addr_ext,
    output logic          wen_ext,
    output logic          ren_ext,
    output logic [31:0]   wdata_ext,
    input  logic [31:0]   rdata_ext,
    output logic [63:0]   addr_ext_2,
    output logic          wen_ext_2,
    output logic          ren_ext_2,
    output logic [63:0]   wdata_ext_2,
    input  logic [63:0]   rdata_ext_2,
    output state_t        state_dbg
);

    state_t           state;
    logic             accept;
    logic [CNT_W-1:0] run_len;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [63:0]      rd_word;

    assign state_dbg = state;
    assign accept    = (state == ST_IDLE) && host.cmd_ready && host.cmd_valid;
    assign run_len   = host.cmd_wdata[CNT_W-1:0];

    // The read strobe is still high in the capture cycle, so it tells which
    // port the data comes from.
    assign rd_word = ren_ext_2 ? rdata_ext_2 : {32'd0, rdata_ext};

    // One counter serves both waits. It is loaded with (length - 1) on
    // acceptance so that its zero flag is high during the last cycle of the
    // read strobe or of the enable window. A RUN with N==0 loads all-ones,
    // which is harmless because the FSM never leaves IDLE for it.
    always_comb begin
        cnt_load_val = CNT_W'(RD_LAT - 1);
        if (host.cmd_op == OP_RUN) begin
            cnt_load_val = run_len - CNT_W'(1);
        end
    end

    assign cnt_dec = ((state == ST_RD_ISSUE) || (state == ST_RD_WAIT) ||
                      (state == ST_RUN)) && !cnt_zero;

    ext_host_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            host.cmd_ready <= 1'b0;
            host.rsp_valid <= 1'b0;
            host.rsp_data  <= '0;
            err            <= 1'b0;
            run_done       <= 1'b0;
            busy           <= 1'b0;
            enable         <= 1'b0;
            addr_ext       <= '0;
            wen_ext        <= 1'b0;
            ren_ext        <= 1'b0;
            wdata_ext      <= '0;
            addr_ext_2     <= '0;
            wen_ext_2      <= 1'b0;
            ren_ext_2      <= 1'b0;
            wdata_ext_2    <= '0;
        end else begin
            // Pulses and write strobes last exactly one cycle.
            err       <= 1'b0;
            run_done  <= 1'b0;
            wen_ext   <= 1'b0;
            wen_ext_2 <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // Also raises ready on the first cycle after reset.
                    host.cmd_ready <= 1'b1;
                    if (accept) begin
                        if (!cmd_legal(host.cmd_op, host.cmd_addr)) begin
                            err <= 1'b1;
                        end else begin
                            case (host.cmd_op)
                                OP_WR_I: begin
                                    addr_ext       <= host.cmd_addr;
                                    wdata_ext      <= host.cmd_wdata[31:0];
                                    wen_ext        <= 1'b1;
                                    state          <= ST_WRITE;
                                    host.cmd_ready <= 1'b0;
                                    busy           <= 1'b1;
                                end
                                OP_WR_D: begin
                                    addr_ext_2     <= host.cmd_addr;
                                    wdata_ext_2    <= host.cmd_wdata;
                                    wen_ext_2      <= 1'b1;
                                    state          <= ST_WRITE;
                                    host.cmd_ready <= 1'b0;
                                    busy           <= 1'b1;
                                end
                                OP_RD_I: begin
                                    addr_ext       <= host.cmd_addr;
                                    ren_ext        <= 1'b1;
                                    state          <= ST_RD_ISSUE;
                                    host.cmd_ready <= 1'b0;
                                    busy           <= 1'b1;
                                end
                                OP_RD_D: begin
                                    addr_ext_2     <= host.cmd_addr;
                                    ren_ext_2      <= 1'b1;
                                    state          <= ST_RD_ISSUE;
                                    host.cmd_ready <= 1'b0;
                                    busy           <= 1'b1;
                                end
                                OP_RUN: begin
                                    if (run_len == '0) begin
                                        run_done <= 1'b1;
                                    end else begin
                                        enable         <= 1'b1;
                                        state          <= ST_RUN;
                                        host.cmd_ready <= 1'b0;
                                        busy           <= 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                ST_WRITE: begin
                    state          <= ST_IDLE;
                    host.cmd_ready <= 1'b1;
                    busy           <= 1'b0;
                end

                ST_RD_ISSUE, ST_RD_WAIT: begin
                    if (cnt_zero) begin
                        host.rsp_data  <= rd_word;
                        host.rsp_valid <= 1'b1;
                        ren_ext        <= 1'b0;
                        ren_ext_2      <= 1'b0;
                        state          <= ST_RESP;
                    end else begin
                        state <= ST_RD_WAIT;
                    end
                end

                ST_RESP: begin
                    if (host.rsp_ready) begin
                        host.rsp_valid <= 1'b0;
                        state          <= ST_IDLE;
                        host.cmd_ready <= 1'b1;
                        busy           <= 1'b0;
                    end
                end

                ST_RUN: begin
                    if (halt || cnt_zero) begin
                        enable         <= 1'b0;
                        run_done       <= 1'b1;
                        state          <= ST_IDLE;
                        host.cmd_ready <= 1'b1;
                        busy           <= 1'b0;
                    end
                end

                default: begin
                    state          <= ST_IDLE;
                    host.cmd_ready <= 1'b1;
                    host.rsp_valid <= 1'b0;
                    busy           <= 1'b0;
                    enable         <= 1'b0;
                    ren_ext        <= 1'b0;
                    ren_ext_2      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_ext_host.sv
module tb_cpu_ext_host;
  import cpu_ext_host_pkg::*;

  localparam int MAIN_LAT = 1;
  localparam int LAT3     = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- main DUT (RD_LAT = 1) ----------------
  cpu_ext_host_if h ();
  logic        err, run_done, busy, halt, enable;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0] wdata_ext, rdata_ext;
  state_t      st_dbg;

  cpu_ext_host #(.RD_LAT(MAIN_LAT), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .host(h),
    .err(err), .run_done(run_done), .busy(busy), .halt(halt), .enable(enable),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .state_dbg(st_dbg)
  );

  // ---------------- second DUT (RD_LAT = 3) ----------------
  cpu_ext_host_if h3 ();
  logic        err_3, run_done_3, busy_3, halt_3, enable_3;
  logic [63:0] addr_ext_3, addr_ext_2_3, wdata_ext_2_3, rdata_ext_2_3;
  logic        wen_ext_3, ren_ext_3, wen_ext_2_3, ren_ext_2_3;
  logic [31:0] wdata_ext_3, rdata_ext_3;
  state_t      st_dbg_3;

  cpu_ext_host #(.RD_LAT(LAT3), .CNT_W(32)) u_dut3 (
    .clk(clk), .rst(rst), .host(h3),
    .err(err_3), .run_done(run_done_3), .busy(busy_3), .halt(halt_3), .enable(enable_3),
    .addr_ext(addr_ext_3), .wen_ext(wen_ext_3), .ren_ext(ren_ext_3),
    .wdata_ext(wdata_ext_3), .rdata_ext(rdata_ext_3),
    .addr_ext_2(addr_ext_2_3), .wen_ext_2(wen_ext_2_3), .ren_ext_2(ren_ext_2_3),
    .wdata_ext_2(wdata_ext_2_3), .rdata_ext_2(rdata_ext_2_3),
    .state_dbg(st_dbg_3)
  );

  // ---------------- SRAM models ----------------
  // Written from the DUT strobes; read data is only valid once the read
  // strobe has been held for the configured latency, random otherwise.
  logic [31:0] sram_i  [logic [63:0]];
  logic [63:0] sram_d  [logic [63:0]];
  logic [31:0] sram_i3 [logic [63:0]];
  logic [63:0] sram_d3 [logic [63:0]];
  int run_i = 0, run_d = 0, run_i3 = 0, run_d3 = 0;

  always @(negedge clk) begin
    if (wen_ext)   sram_i[addr_ext]    = wdata_ext;
    if (wen_ext_2) sram_d[addr_ext_2]  = wdata_ext_2;
    run_i = ren_ext   ? run_i + 1 : 0;
    run_d = ren_ext_2 ? run_d + 1 : 0;
    if (ren_ext && run_i >= MAIN_LAT) rdata_ext = sram_i.exists(addr_ext) ? sram_i[addr_ext] : 32'h0;
    else rdata_ext = $urandom;
    if (ren_ext_2 && run_d >= MAIN_LAT) rdata_ext_2 = sram_d.exists(addr_ext_2) ? sram_d[addr_ext_2] : 64'h0;
    else rdata_ext_2 = {$urandom, $urandom};

    if (wen_ext_3)   sram_i3[addr_ext_3]   = wdata_ext_3;
    if (wen_ext_2_3) sram_d3[addr_ext_2_3] = wdata_ext_2_3;
    run_i3 = ren_ext_3   ? run_i3 + 1 : 0;
    run_d3 = ren_ext_2_3 ? run_d3 + 1 : 0;
    if (ren_ext_3 && run_i3 >= LAT3) rdata_ext_3 = sram_i3.exists(addr_ext_3) ? sram_i3[addr_ext_3] : 32'h0;
    else rdata_ext_3 = $urandom;
    if (ren_ext_2_3 && run_d3 >= LAT3) rdata_ext_2_3 = sram_d3.exists(addr_ext_2_3) ? sram_d3[addr_ext_2_3] : 64'h0;
    else rdata_ext_2_3 = {$urandom, $urandom};
  end

  // ---------------- reference model and scoreboard ----------------
  logic [31:0] exp_i [logic [63:0]];
  logic [63:0] exp_d [logic [63:0]];
  logic [63:0] exp_q [$];

  int strobe_cycles = 0, err_pulses = 0, done_pulses = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle invariants: at most one strobe, never a strobe with enable.
  always @(negedge clk) begin : mon
    int s, s3;
    s  = int'(wen_ext) + int'(ren_ext) + int'(wen_ext_2) + int'(ren_ext_2);
    s3 = int'(wen_ext_3) + int'(ren_ext_3) + int'(wen_ext_2_3) + int'(ren_ext_2_3);
    if (s != 0) strobe_cycles++;
    if (err === 1'b1) err_pulses++;
    if (run_done === 1'b1) done_pulses++;
    chk("strobe_excl", 64'((s <= 1) && !(s != 0 && enable === 1'b1)), 64'd1);
    chk("strobe_excl_3", 64'((s3 <= 1) && !(s3 != 0 && enable_3 === 1'b1)), 64'd1);
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic issue(input logic [2:0] op, input logic [63:0] addr, input logic [63:0] wdata);
    int n = 0;
    while (h.cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", 64'(h.cmd_ready), 64'd1);
    h.cmd_valid = 1'b1; h.cmd_op = op; h.cmd_addr = addr; h.cmd_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    h.cmd_valid = 1'b0;
  endtask

  task automatic issue3(input logic [2:0] op, input logic [63:0] addr, input logic [63:0] wdata);
    int n = 0;
    while (h3.cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready_wait_3", 64'(h3.cmd_ready), 64'd1);
    h3.cmd_valid = 1'b1; h3.cmd_op = op; h3.cmd_addr = addr; h3.cmd_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    h3.cmd_valid = 1'b0;
  endtask

  task automatic do_write(input bit is_d, input logic [63:0] addr, input logic [63:0] data);
    issue(is_d ? OP_WR_D : OP_WR_I, addr, data);
    if (is_d) begin
      chk("wen_d", 64'(wen_ext_2), 64'd1);
      chk("wen_i_quiet", 64'(wen_ext), 64'd0);
      chk("addr_d", addr_ext_2, addr);
      chk("wdata_d", wdata_ext_2, data);
      exp_d[addr] = data;
    end else begin
      chk("wen_i", 64'(wen_ext), 64'd1);
      chk("wen_d_quiet", 64'(wen_ext_2), 64'd0);
      chk("addr_i", addr_ext, addr);
      chk("wdata_i", 64'(wdata_ext), {32'h0, data[31:0]});
      exp_i[addr] = data[31:0];
    end
    chk("write_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("write_wen_off", 64'({wen_ext, wen_ext_2}), 64'd0);
    chk("write_ready_back", 64'(h.cmd_ready), 64'd1);
  endtask

  task automatic do_read(input bit is_d, input logic [63:0] addr, input int hold);
    int n = 0;
    if (is_d) exp_q.push_back(exp_d.exists(addr) ? exp_d[addr] : 64'h0);
    else      exp_q.push_back({32'h0, exp_i.exists(addr) ? exp_i[addr] : 32'h0});
    issue(is_d ? OP_RD_D : OP_RD_I, addr, 64'h0);
    chk("rd_ren", 64'(is_d ? ren_ext_2 : ren_ext), 64'd1);
    chk("rd_addr", is_d ? addr_ext_2 : addr_ext, addr);
    chk("rd_no_early_valid", 64'(h.rsp_valid), 64'd0);
    while (h.rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("rd_latency", 64'(n), 64'(MAIN_LAT));
    chk("rd_ren_off", 64'({ren_ext, ren_ext_2}), 64'd0);
    for (int i = 0; i < hold; i++) begin
      chk("rsp_hold_valid", 64'(h.rsp_valid), 64'd1);
      chk("rsp_hold_data", h.rsp_data, exp_q[0]);
      @(negedge clk);
    end
    h.rsp_ready = 1'b1;
    chk("rsp_data", h.rsp_data, exp_q.pop_front());
    @(negedge clk);
    h.rsp_ready = 1'b0;
    chk("rsp_consumed", 64'(h.rsp_valid), 64'd0);
    chk("rd_ready_back", 64'(h.cmd_ready), 64'd1);
    chk("rd_busy_off", 64'(busy), 64'd0);
  endtask

  // Expected enable length: N cycles, cut short at cycle k if halt is
  // raised during cycle k of the window.
  task automatic do_run(input int n_cycles, input int halt_at);
    int n = 0;
    int exp_n;
    int d0;
    exp_n = (halt_at > 0 && halt_at < n_cycles) ? halt_at : n_cycles;
    d0 = done_pulses;
    issue(OP_RUN, {$urandom, $urandom}, 64'(n_cycles));
    chk("run_busy", 64'(busy), 64'(n_cycles != 0));
    while (enable === 1'b1 && n < 400) begin
      n++;
      halt = (n == halt_at);
      @(negedge clk);
    end
    halt = 1'b0;
    chk("run_len", 64'(n), 64'(exp_n));
    chk("run_done_pulse", 64'(run_done), 64'd1);
    chk("run_busy_off", 64'(busy), 64'd0);
    chk("run_ready_back", 64'(h.cmd_ready), 64'd1);
    @(negedge clk);
    chk("run_done_once", 64'(done_pulses - d0), 64'd1);
    chk("run_enable_off", 64'(enable), 64'd0);
  endtask

  task automatic do_illegal(input logic [2:0] op, input logic [63:0] addr);
    int e0, s0;
    e0 = err_pulses;
    s0 = strobe_cycles;
    issue(op, addr, {$urandom, $urandom});
    chk("err_pulse", 64'(err), 64'd1);
    chk("err_ready", 64'(h.cmd_ready), 64'd1);
    chk("err_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("err_single", 64'(err), 64'd0);
    chk("err_count", 64'(err_pulses - e0), 64'd1);
    chk("err_no_strobe", 64'(strobe_cycles - s0), 64'd0);
  endtask

  task automatic read3(input bit is_d, input logic [63:0] addr, input logic [63:0] exp);
    int n = 0;
    issue3(is_d ? OP_RD_D : OP_RD_I, addr, 64'h0);
    while ((is_d ? ren_ext_2_3 : ren_ext_3) === 1'b1 && n < 20) begin
      chk("rd3_addr_stable", is_d ? addr_ext_2_3 : addr_ext_3, addr);
      chk("rd3_valid_low", 64'(h3.rsp_valid), 64'd0);
      n++;
      @(negedge clk);
    end
    chk("rd3_ren_cycles", 64'(n), 64'(LAT3));
    chk("rd3_valid", 64'(h3.rsp_valid), 64'd1);
    chk("rd3_data", h3.rsp_data, exp);
    h3.rsp_ready = 1'b1;
    @(negedge clk);
    h3.rsp_ready = 1'b0;
    chk("rd3_consumed", 64'(h3.rsp_valid), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] v;
    int d0;
    rst = 1'b1; halt = 1'b0; halt_3 = 1'b0;
    h.cmd_valid = 1'b0;  h.cmd_op = 3'b0;  h.cmd_addr = '0;  h.cmd_wdata = '0;  h.rsp_ready = 1'b0;
    h3.cmd_valid = 1'b0; h3.cmd_op = 3'b0; h3.cmd_addr = '0; h3.cmd_wdata = '0; h3.rsp_ready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(h.cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(h.rsp_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_run_done", 64'(run_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_enable", 64'(enable), 64'd0);
    chk("rst_strobes", 64'({wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 64'd0);
    chk("rst_state", 64'(st_dbg), 64'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(h.cmd_ready), 64'd1);

    // directed writes and reads
    do_write(1'b0, 64'h10, 64'h0000_0000_0050_0093);
    do_write(1'b1, 64'h8, 64'h0000_0000_DEAD_BEEF);
    do_read(1'b1, 64'h8, 3);
    do_read(1'b0, 64'h10, 0);

    // runs
    do_run(5, 0);
    do_run(0, 0);
    do_run(100, 10);
    do_run(1, 0);

    // illegal commands
    do_illegal(OP_RD_I, 64'h6);
    do_illegal(3'b111, 64'h0);
    do_illegal(OP_WR_D, 64'h104);
    do_illegal(OP_WR_I, 64'h2);
    do_illegal(3'b101, 64'h40);

    // randomized traffic against the reference model
    for (int it = 0; it < 60; it++) begin
      int kind;
      int idx;
      kind = $urandom_range(0, 5);
      idx  = $urandom_range(0, 15);
      case (kind)
        0: do_write(1'b0, 64'(idx * 4), {$urandom, $urandom});
        1: do_write(1'b1, 64'h100 + 64'(idx * 8), {$urandom, $urandom});
        2: do_read(1'b0, 64'(idx * 4), $urandom_range(0, 3));
        3: do_read(1'b1, 64'h100 + 64'(idx * 8), $urandom_range(0, 3));
        4: do_run($urandom_range(0, 20), $urandom_range(0, 25));
        default: do_illegal(3'(5 + $urandom_range(0, 2)), {$urandom, $urandom});
      endcase
    end

    // reset during a read: strobe and response are abandoned
    issue(OP_RD_D, 64'h8, 64'h0);
    chk("rst_rd_ren_before", 64'(ren_ext_2), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rd_ren", 64'(ren_ext_2), 64'd0);
    chk("rst_rd_valid", 64'(h.rsp_valid), 64'd0);
    chk("rst_rd_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rd_ready_back", 64'(h.cmd_ready), 64'd1);
    chk("rst_rd_no_rsp", 64'(h.rsp_valid), 64'd0);

    // reset during a RUN: enable drops, no run_done
    issue(OP_RUN, 64'h0, 64'd50);
    repeat (3) @(negedge clk);
    chk("rst_run_enable_before", 64'(enable), 64'd1);
    d0 = done_pulses;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_run_enable", 64'(enable), 64'd0);
    chk("rst_run_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_run_ready_back", 64'(h.cmd_ready), 64'd1);
    chk("rst_run_no_done", 64'(done_pulses - d0), 64'd0);
    chk("rst_run_enable_stays", 64'(enable), 64'd0);

    // longer read latency on the second instance
    v = {$urandom, $urandom};
    issue3(OP_WR_D, 64'h20, v);
    chk("wr3_wen_d", 64'(wen_ext_2_3), 64'd1);
    @(negedge clk);
    read3(1'b1, 64'h20, v);
    issue3(OP_WR_I, 64'h24, 64'h1234_5678_9ABC_DEF0);
    chk("wr3_wen_i", 64'(wen_ext_3), 64'd1);
    @(negedge clk);
    read3(1'b0, 64'h24, 64'h0000_0000_9ABC_DEF0);

    // reset while waiting for read data
    issue3(OP_RD_I, 64'h24, 64'h0);
    @(negedge clk);
    chk("rd3_in_wait", 64'(st_dbg_3), 64'(ST_RD_WAIT));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wait_ren", 64'(ren_ext_3), 64'd0);
    chk("rst_wait_valid", 64'(h3.rsp_valid), 64'd0);
    chk("rst_wait_state", 64'(st_dbg_3), 64'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wait_ready_back", 64'(h3.cmd_ready), 64'd1);
    chk("rst_wait_no_rsp", 64'(h3.rsp_valid), 64'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
